// File: rtl/reg_operand_fetch.sv
// Register-file initiator: writeback issue, two-operand fetch with one-cycle read latency.
// Optional macro REG_OPERAND_FWD_EN forwards matching writebacks into pending operands.
module reg_operand_fetch #(
    parameter int addressBitWidth = 4,
    parameter int dataBitWidth    = 16,
    parameter int memoryDepth     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [addressBitWidth-1:0] req_rd_addr,
    input  logic [addressBitWidth-1:0] req_rs_addr,
    input  logic                       req_rs_use,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  logic [addressBitWidth-1:0] wb_addr,
    input  logic [dataBitWidth-1:0]    wb_data,
    output logic                       rf_rd_en,
    output logic                       rf_rs_en,
    output logic                       rf_wr_en,
    output logic [addressBitWidth-1:0] rf_rd_addr,
    output logic [addressBitWidth-1:0] rf_rs_addr,
    output logic [dataBitWidth-1:0]    rf_wr_data,
    input  logic [dataBitWidth-1:0]    rf_rd_data,
    input  logic [dataBitWidth-1:0]    rf_rs_data,
    input  logic                       rf_valid,
    output logic                       op_valid,
    input  logic                       op_ready,
    output logic [dataBitWidth-1:0]    op_rd_data,
    output logic [dataBitWidth-1:0]    op_rs_data,
    output logic                       op_err
);

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_t;

    localparam logic [31:0] Depth = 32'(memoryDepth);

    state_t                     state_q;
    logic [addressBitWidth-1:0] rd_addr_q;
    logic [addressBitWidth-1:0] rs_addr_q;
    logic                       rs_use_q;

    logic wb_hit_rd;
    logic wb_hit_rs;
    logic wb_allow;
    logic addr_oob;

    assign wb_hit_rd = (wb_addr == rd_addr_q);
    assign wb_hit_rs = rs_use_q && (wb_addr == rs_addr_q);

`ifdef REG_OPERAND_FWD_EN
    assign wb_allow = 1'b1;
`else
    // Hold off writes to a pending operand so it keeps the value read at issue.
    assign wb_allow = ~(wb_hit_rd | wb_hit_rs);
`endif

    // Catches addresses beyond the implemented depth when the address space is wider.
    assign addr_oob = (32'(rd_addr_q) >= Depth) || (rs_use_q && (32'(rs_addr_q) >= Depth));

    always_comb begin
        req_ready  = 1'b0;
        wb_ready   = 1'b0;
        rf_rd_en   = 1'b0;
        rf_rs_en   = 1'b0;
        rf_wr_en   = 1'b0;
        rf_rd_addr = '0;
        rf_rs_addr = '0;
        rf_wr_data = '0;
        unique case (state_q)
            StIdle: begin
                if (wb_valid) begin
                    wb_ready   = 1'b1;
                    rf_wr_en   = 1'b1;
                    rf_rd_addr = wb_addr;
                    rf_wr_data = wb_data;
                end else if (req_valid) begin
                    req_ready  = 1'b1;
                    rf_rd_en   = 1'b1;
                    rf_rs_en   = req_rs_use;
                    rf_rd_addr = req_rd_addr;
                    rf_rs_addr = req_rs_addr;
                end
            end
            StWait, StHold: begin
                if (wb_valid && wb_allow) begin
                    wb_ready   = 1'b1;
                    rf_wr_en   = 1'b1;
                    rf_rd_addr = wb_addr;
                    rf_wr_data = wb_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rd_addr_q  <= '0;
            rs_addr_q  <= '0;
            rs_use_q   <= 1'b0;
            op_valid   <= 1'b0;
            op_err     <= 1'b0;
            op_rd_data <= '0;
            op_rs_data <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!wb_valid && req_valid) begin
                        rd_addr_q <= req_rd_addr;
                        rs_addr_q <= req_rs_addr;
                        rs_use_q  <= req_rs_use;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    op_rd_data <= rf_rd_data;
                    op_rs_data <= rs_use_q ? rf_rs_data : '0;
                    op_err     <= ~rf_valid | addr_oob;
                    op_valid   <= 1'b1;
                    state_q    <= StHold;
`ifdef REG_OPERAND_FWD_EN
                    if (wb_valid && wb_hit_rd) op_rd_data <= wb_data;
                    if (wb_valid && wb_hit_rs) op_rs_data <= wb_data;
`endif
                end
                StHold: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        state_q  <= StIdle;
                    end
`ifdef REG_OPERAND_FWD_EN
                    if (wb_valid && wb_hit_rd) op_rd_data <= wb_data;
                    if (wb_valid && wb_hit_rs) op_rs_data <= wb_data;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Directed bench for reg_operand_fetch with a behavioural clocked register file.
module tb_reg_operand_fetch;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_rd_addr;
    logic [AW-1:0] req_rs_addr;
    logic          req_rs_use;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          rf_rd_en;
    logic          rf_rs_en;
    logic          rf_wr_en;
    logic [AW-1:0] rf_rd_addr;
    logic [AW-1:0] rf_rs_addr;
    logic [DW-1:0] rf_wr_data;
    logic [DW-1:0] rf_rd_data;
    logic [DW-1:0] rf_rs_data;
    logic          rf_valid;
    logic          op_valid;
    logic          op_ready;
    logic [DW-1:0] op_rd_data;
    logic [DW-1:0] op_rs_data;
    logic          op_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mem [16] = '{default: '0};

    reg_operand_fetch #(
        .addressBitWidth(AW),
        .dataBitWidth   (DW),
        .memoryDepth    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rd_addr(req_rd_addr),
        .req_rs_addr(req_rs_addr),
        .req_rs_use (req_rs_use),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .rf_rd_en   (rf_rd_en),
        .rf_rs_en   (rf_rs_en),
        .rf_wr_en   (rf_wr_en),
        .rf_rd_addr (rf_rd_addr),
        .rf_rs_addr (rf_rs_addr),
        .rf_wr_data (rf_wr_data),
        .rf_rd_data (rf_rd_data),
        .rf_rs_data (rf_rs_data),
        .rf_valid   (rf_valid),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_rd_data (op_rd_data),
        .op_rs_data (op_rs_data),
        .op_err     (op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: signed addresses, negative reads give 0 and clear rf_valid; writes hold reads.
    always @(posedge clk) begin
        if (rf_wr_en) begin
            mem[rf_rd_addr] <= rf_wr_data;
        end else if (rf_rd_en) begin
            rf_rd_data <= rf_rd_addr[AW-1] ? '0 : mem[rf_rd_addr];
            rf_rs_data <= (rf_rs_en && !rf_rs_addr[AW-1]) ? mem[rf_rs_addr] : '0;
            rf_valid   <= !rf_rd_addr[AW-1] && !(rf_rs_en && rf_rs_addr[AW-1]);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_rd_addr = '0; req_rs_addr = '0; req_rs_use = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0; op_ready = 1'b0;
        #1;
        check("rst_op_valid", op_valid, 0);
        check("rst_op_err", op_err, 0);
        check("rst_op_rd", op_rd_data, 0);
        check("rst_req_ready", req_ready, 0);
        tick(); rst = 1'b0; tick();

        // 1: preload R5, R3 then fetch both
        wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 16'h0005; #1;
        check("t1_wb_ready", wb_ready, 1);
        check("t1_rf_wr_en", rf_wr_en, 1);
        check("t1_rf_wr_addr", rf_rd_addr, 5);
        tick();
        wb_addr = 4'd3; wb_data = 16'h1234; tick();
        wb_valid = 1'b0;
        req_valid = 1'b1; req_rd_addr = 4'd3; req_rs_addr = 4'd5; req_rs_use = 1'b1;
        op_ready = 1'b1; #1;
        check("t1_req_ready", req_ready, 1);
        check("t1_rf_rs_en", rf_rs_en, 1);
        check("t1_rf_rs_addr", rf_rs_addr, 5);
        tick(); req_valid = 1'b0; #1;
        check("t1_op_valid_t1", op_valid, 0);
        tick(); #1;
        check("t1_op_valid_t2", op_valid, 1);
        check("t1_op_rd", op_rd_data, 16'h1234);
        check("t1_op_rs", op_rs_data, 16'h0005);
        check("t1_op_err", op_err, 0);
        tick(); #1;
        check("t1_consumed", op_valid, 0);

        // 2: writeback wins over simultaneous request
        wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 16'h4321;
        req_valid = 1'b1; req_rd_addr = 4'd3; req_rs_use = 1'b0; op_ready = 1'b0; #1;
        check("t2_wb_ready", wb_ready, 1);
        check("t2_req_blocked", req_ready, 0);
        tick(); wb_valid = 1'b0; #1;
        check("t2_req_ready", req_ready, 1);
        tick(); req_valid = 1'b0; tick(); #1;
        check("t2_op_rd", op_rd_data, 16'h4321);
        check("t2_op_rs", op_rs_data, 16'h0000);

        // 3: stall in HOLD for three cycles, consume on the fourth
        req_valid = 1'b1; req_rd_addr = 4'h9; req_rs_use = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_hold_valid", op_valid, 1);
            check("t3_hold_rd", op_rd_data, 16'h4321);
            check("t3_hold_req_ready", req_ready, 0);
            tick();
        end
        op_ready = 1'b1; #1;
        check("t3_c4_req_ready", req_ready, 0);
        tick(); op_ready = 1'b0; #1;
        check("t3_released", op_valid, 0);
        check("t3_idle_accept", req_ready, 1);

        // 4: negative address
        tick(); req_valid = 1'b0; tick(); #1;
        check("t4_op_valid", op_valid, 1);
        check("t4_op_err", op_err, 1);
        check("t4_op_rd", op_rd_data, 0);
        check("t4_op_rs", op_rs_data, 0);
        op_ready = 1'b1; tick(); op_ready = 1'b0;

        // 5: writebacks while operands held
        req_valid = 1'b1; req_rd_addr = 4'd2; req_rs_addr = 4'd5; req_rs_use = 1'b1; #1;
        check("t5_req_ready", req_ready, 1);
        tick(); req_valid = 1'b0; tick(); #1;
        check("t5_op_rd_init", op_rd_data, 16'h0000);
        check("t5_op_rs_init", op_rs_data, 16'h0005);
        wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 16'h0077; #1;
        check("t5_wb_nomatch", wb_ready, 1);
        tick();
        wb_addr = 4'd2; wb_data = 16'hBEEF; #1;
`ifdef REG_OPERAND_FWD_EN
        check("t5_fwd_wb_ready", wb_ready, 1);
        tick(); wb_valid = 1'b0; #1;
        check("t5_fwd_op_rd", op_rd_data, 16'hBEEF);
        check("t5_fwd_op_rs", op_rs_data, 16'h0005);
        op_ready = 1'b1; tick(); op_ready = 1'b0;
`else
        check("t5_blk_wb_ready", wb_ready, 0);
        check("t5_blk_wr_en", rf_wr_en, 0);
        tick(); #1;
        check("t5_blk_wb_ready2", wb_ready, 0);
        check("t5_blk_op_rd", op_rd_data, 16'h0000);
        op_ready = 1'b1; #1;
        check("t5_blk_wb_hs", wb_ready, 0);
        tick(); op_ready = 1'b0; #1;
        check("t5_blk_wb_after", wb_ready, 1);
        tick(); wb_valid = 1'b0;
`endif
        req_valid = 1'b1; req_rd_addr = 4'd2; req_rs_addr = 4'd7; req_rs_use = 1'b1;
        tick(); req_valid = 1'b0; tick(); #1;
        check("t5_readback_r2", op_rd_data, 16'hBEEF);
        check("t5_readback_r7", op_rs_data, 16'h0077);
        op_ready = 1'b1; tick(); op_ready = 1'b0;

        // 6: asynchronous reset during WAIT
        req_valid = 1'b1; req_rd_addr = 4'd3; req_rs_use = 1'b0;
        tick(); req_valid = 1'b0; #1;
        rst = 1'b1; #1;
        check("t6_op_valid", op_valid, 0);
        check("t6_op_err", op_err, 0);
        check("t6_op_rd", op_rd_data, 0);
        check("t6_op_rs", op_rs_data, 0);
        tick(); #1; rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check("t6_no_pulse", op_valid, 0);
        end
        req_valid = 1'b1; #1;
        check("t6_idle", req_ready, 1);
        req_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
